// File: rtl/pe_acc_if.sv
// Stream and weight-load bundle for pe_acc.
// The master side drives pixels, weights and o_ready; the slave (pe_acc) returns
// p_ready and the result channel.
interface pe_acc_if #(
    parameter int TAPS = 3,
    parameter int ROWS = 3,
    parameter int PW   = 8,
    parameter int WW   = 8,
    parameter int OW   = 16
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                   w_load;
    logic [RW-1:0]          w_row;
    logic [TAPS*WW-1:0]     w_in;
    logic [TAPS*PW-1:0]     p;
    logic                   p_valid;
    logic                   p_ready;
    logic                   relu_en;
    logic signed [OW-1:0]   o;
    logic                   o_valid;
    logic                   o_ready;
    logic                   o_sat;

    modport master (
        output w_load, w_row, w_in, p, p_valid, relu_en, o_ready,
        input  p_ready, o, o_valid, o_sat
    );

    modport slave (
        input  w_load, w_row, w_in, p, p_valid, relu_en, o_ready,
        output p_ready, o, o_valid, o_sat
    );
endinterface

// File: rtl/pe_acc.sv
// pe_acc: multi-row convolution processing element.
// Each accepted vector of TAPS unsigned pixels is multiplied by the weight row
// selected by the row counter; ROWS consecutive row sums are accumulated into one
// shifted, optionally ReLU-clamped, saturated output. Three pipeline stages
// (products, row sum, accumulate/output) all advance on a single enable that
// drops only while a finished result is waiting for o_ready.
module pe_acc #(
    parameter int TAPS  = 3,
    parameter int ROWS  = 3,
    parameter int PW    = 8,
    parameter int WW    = 8,
    parameter int OW    = 16,
    parameter int SHIFT = 0
) (
    input  logic      clk,
    input  logic      rst,
    pe_acc_if.slave   bus
);
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PRW = PW + WW + 1;                       // one signed product
    localparam int SW  = PRW + $clog2(TAPS);                // one row sum
    localparam int AW  = PW + WW + 1 + $clog2(TAPS * ROWS); // window accumulator
    localparam int CW  = (AW > OW) ? AW : OW;               // saturation compare width

    localparam logic signed [CW-1:0] SAT_MAX = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN = {{(CW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    localparam logic signed [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] OUT_MIN = {1'b1, {(OW-1){1'b0}}};

    // weight bank (deliberately outside reset so coefficients survive a pipeline flush)
    logic signed [WW-1:0]  w_bank_r [ROWS][TAPS];

    // control
    logic                  en_s;
    logic                  accept_s;
    logic [RW-1:0]         row_r;
    logic                  first_s;
    logic                  last_s;

    // stage 1
    logic signed [PRW-1:0] pix_ext_s [TAPS];
    logic signed [PRW-1:0] w_ext_s   [TAPS];
    logic signed [PRW-1:0] prod_s    [TAPS];
    logic signed [PRW-1:0] prod_r    [TAPS];
    logic                  v1_r;
    logic                  first1_r;
    logic                  last1_r;
    logic                  relu1_r;

    // stage 2
    logic signed [SW-1:0]  rowsum_s;
    logic signed [SW-1:0]  rowsum_r;
    logic                  v2_r;
    logic                  first2_r;
    logic                  last2_r;
    logic                  relu2_r;

    // stage 3
    logic signed [AW-1:0]  acc_r;
    logic signed [AW-1:0]  base_s;
    logic signed [AW-1:0]  total_s;
    logic signed [AW-1:0]  shifted_s;
    logic signed [AW-1:0]  relu_s;
    logic signed [CW-1:0]  wide_s;
    logic signed [OW-1:0]  sat_val_s;
    logic                  sat_flag_s;
    logic signed [OW-1:0]  o_r;
    logic                  o_valid_r;
    logic                  o_sat_r;

    assign en_s         = !(o_valid_r && !bus.o_ready);
    assign bus.p_ready  = en_s && !rst;
    assign accept_s     = bus.p_valid && bus.p_ready;
    assign first_s      = (row_r == '0);
    assign last_s       = (row_r == RW'(ROWS - 1));

    assign bus.o        = o_r;
    assign bus.o_valid  = o_valid_r;
    assign bus.o_sat    = o_sat_r;

    // Weight row write; a vector accepted on the same edge still sees the old row.
    always_ff @(posedge clk) begin
        if (bus.w_load && (int'(bus.w_row) < ROWS)) begin
            for (int k = 0; k < TAPS; k++) begin
                w_bank_r[bus.w_row][k] <= bus.w_in[(TAPS-1-k)*WW +: WW];
            end
        end
    end

    // Row counter: one step per accepted vector, wrapping at the end of the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r <= '0;
        end else if (accept_s) begin
            if (last_s) begin
                row_r <= '0;
            end else begin
                row_r <= row_r + RW'(1);
            end
        end
    end

    // Per-tap products: pixel zero-extended to a signed operand times current-row weight.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            pix_ext_s[k] = PRW'({1'b0, bus.p[(TAPS-1-k)*PW +: PW]});
            w_ext_s[k]   = PRW'(w_bank_r[row_r][k]);
            prod_s[k]    = pix_ext_s[k] * w_ext_s[k];
        end
    end

    // Stage 1 register: products plus window tags and the ReLU request.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r     <= 1'b0;
            first1_r <= 1'b0;
            last1_r  <= 1'b0;
            relu1_r  <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                prod_r[k] <= '0;
            end
        end else if (en_s) begin
            v1_r <= accept_s;
            if (accept_s) begin
                first1_r <= first_s;
                last1_r  <= last_s;
                relu1_r  <= bus.relu_en;
                for (int k = 0; k < TAPS; k++) begin
                    prod_r[k] <= prod_s[k];
                end
            end
        end
    end

    // Adder tree over the registered products.
    always_comb begin
        rowsum_s = '0;
        for (int k = 0; k < TAPS; k++) begin
            rowsum_s = rowsum_s + SW'(prod_r[k]);
        end
    end

    // Stage 2 register: row sum with tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r     <= 1'b0;
            rowsum_r <= '0;
            first2_r <= 1'b0;
            last2_r  <= 1'b0;
            relu2_r  <= 1'b0;
        end else if (en_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                rowsum_r <= rowsum_s;
                first2_r <= first1_r;
                last2_r  <= last1_r;
                relu2_r  <= relu1_r;
            end
        end
    end

    // Window sum, floor shift, optional ReLU and signed saturation of the result.
    always_comb begin
        if (first2_r) begin
            base_s = '0;
        end else begin
            base_s = acc_r;
        end
        total_s   = base_s + AW'(rowsum_r);
        shifted_s = total_s >>> SHIFT;
        if (relu2_r && shifted_s[AW-1]) begin
            relu_s = '0;
        end else begin
            relu_s = shifted_s;
        end
        wide_s = CW'(relu_s);
        if (wide_s > SAT_MAX) begin
            sat_val_s  = OUT_MAX;
            sat_flag_s = 1'b1;
        end else if (wide_s < SAT_MIN) begin
            sat_val_s  = OUT_MIN;
            sat_flag_s = 1'b1;
        end else begin
            sat_val_s  = wide_s[OW-1:0];
            sat_flag_s = 1'b0;
        end
    end

    // Accumulator: restarts on a first row, holds through bubbles and stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
        end else if (en_s && v2_r) begin
            acc_r <= total_s;
        end
    end

    // Output register: loads on a last row, holds while stalled, clears on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_r       <= '0;
            o_valid_r <= 1'b0;
            o_sat_r   <= 1'b0;
        end else if (en_s && v2_r && last2_r) begin
            o_r       <= sat_val_s;
            o_valid_r <= 1'b1;
            o_sat_r   <= sat_flag_s;
        end else if (o_valid_r && bus.o_ready) begin
            o_valid_r <= 1'b0;
        end
    end
endmodule

// File: doc/pe_acc.md
# pe_acc

Parametrised successor to the 3-tap processing element. Each cycle it accepts one vector of TAPS unsigned pixels and multiplies it by a per-row bank of signed weights. It accumulates ROWS consecutive row dot-products into one output, which suits a full K×K convolution window. The datapath is a 3-stage pipeline with valid/ready backpressure, output scaling (arithmetic shift), optional ReLU, and signed saturation. It sits between the line-buffer/pixel streamer and the output DMA packer.

## Interface
- TAPS, 3, pixels (and weights) per row vector
- ROWS, 3, row vectors accumulated per output
- PW, 8, pixel width (unsigned)
- WW, 8, weight width (signed)
- OW, 16, output width (signed)
- SHIFT, 0, arithmetic right shift applied to the final sum
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- w_load  in  1  write the weight row selected by w_row
- w_row  in  $clog2(ROWS)  weight row index
- w_in  in  TAPS*WW  weights; tap 0 in MSBs
- p  in  TAPS*PW  pixel vector; tap 0 in MSBs
- p_valid  in  1  pixel vector valid
- p_ready  out  1  pixel vector accepted when p_valid && p_ready
- relu_en  in  1  clamp negative results to 0; sampled with the last row
- o  out  OW  signed result
- o_valid  out  1  result valid
- o_ready  in  1  downstream accepts result
- o_sat  out  1  result was saturated; qualified by o_valid

## Operation
- Weight bank: ROWS×TAPS registers. A w_load write takes effect for vectors accepted in the following cycle. The bank is not cleared by rst. Reloading mid-window is legal; each vector uses whichever bank row is current when it is accepted.
- Row counter `row` (0..ROWS-1): advances on every accept and wraps after ROWS-1. A vector accepted with row==0 is tagged first; one accepted with row==ROWS-1 is tagged last. When ROWS==1, every vector is both first and last.
- Stage 1: each pixel is zero-extended to PW+1 bits and multiplied by its weight w[row][k]. The TAPS signed products are registered along with the first/last tags.
- Stage 2: adder tree over the products; the row sum and tags are registered.
- Stage 3: accumulator width AW = PW+WW+1+$clog2(TAPS*ROWS), no overflow.
  - first: acc <= rowsum.
  - otherwise: acc <= acc + rowsum.
  - last: compute s = (acc_or_0 + rowsum) >>> SHIFT, rounding toward -inf.
  - If relu_en && s<0, then s=0.
  - Saturate s to [-2^(OW-1), 2^(OW-1)-1]; o_sat=1 if clamped.
  - Load o and set o_valid.
- Handshake: en = !(o_valid && !o_ready). All stages advance only when en=1.
- p_ready = en && !rst.
- o, o_valid and o_sat hold while o_valid && !o_ready.
- o_valid clears on handshake unless a new result loads in the same cycle.

## Timing
- Reset values: o=0, o_valid=0, o_sat=0, p_ready=0 during rst, internal valids=0, row=0, acc=0.
- p_ready=1 in the first cycle after rst deasserts.
- rst mid-window discards all partial sums and in-flight stages. The next accepted vector is row 0.
- Latency: if the last row is accepted in cycle t, o_valid is high in cycle t+3 (no stall).
- Throughput: one vector per cycle, one result every ROWS accepted vectors.
- A stall freezes every stage. No vector is lost or duplicated. p_ready drops in the same cycle that o_valid && !o_ready holds.
- p_valid=0 bubbles leave row unchanged. Pipeline valids propagate bubbles, and acc holds through them.
- Simultaneous o_ready and a new result: the new result loads in the same edge and o_valid stays 1.
- w_load while p_valid && p_ready: the vector accepted in that cycle uses the old weights.

## Test plan
- Reset: assert rst 2 cycles mid-stream → o=0, o_valid=0, o_sat=0, p_ready=0 during rst, p_ready=1 the cycle after release.
- Basic: all weights 1, three vectors {10,20,30}, o_ready=1 → o=180, o_valid exactly 3 cycles after the third accept, o_sat=0.
- Saturation/ReLU: all weights -128, pixels 255 → sum -293760, o=-32768, o_sat=1. Repeat with relu_en=1 → o=0, o_sat=0.
- Backpressure: 9 back-to-back vectors (weights 1, pixels 1), o_ready low for 5 cycles after first o_valid → three results of 9, held stable while stalled, p_ready low during stall, none lost.
- SHIFT=2 build: window sums 183 and -183 → o=45 and o=-46.
- Reset mid-window: rst after 2 accepted rows, then rows {1,1,1}×3 with weights 1 → o=9, earlier partials discarded.
